// File: rtl/tlm_mem_target_p_if.sv
// Request/response channel bundle for the parametrised TLM memory target.
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid and ready are both
// high; a source holds valid and its payload stable until that edge, and valid never depends on ready.
interface tlm_mem_target_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              req_valid_i;
    logic              req_ready_o;
    logic [1:0]        req_cmd_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_data_i;
    logic [BYTES-1:0]  req_be_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic [1:0]        rsp_status_o;

    modport master (
        output req_valid_i, req_cmd_i, req_addr_i, req_data_i, req_be_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o
    );

    modport slave (
        input  req_valid_i, req_cmd_i, req_addr_i, req_data_i, req_be_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o
    );
endinterface

// File: rtl/tlm_mem_target_p.sv
// Generic-payload memory target: one transaction at a time, byte-enabled read/write with address and
// command checking, programmable response latency, and saturating transaction/error counters.
module tlm_mem_target_p #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RSP_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_BASE = DATA_W'(32'hAA00_0000)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tlm_mem_target_p_if.slave    bus,
    output logic                 end_sim_o,
    output logic [15:0]          txn_cnt_o,
    output logic [15:0]          err_cnt_o,
    output logic [1:0]           dbg_state
);
    localparam int BYTES = DATA_W / 8;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(RSP_LAT + 1) + 1;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_END   = 2'd3;

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_BE   = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_e;

    function automatic logic [DEPTH*DATA_W-1:0] init_image();
        logic [DEPTH*DATA_W-1:0] img;
        img = '0;
        for (int i = 0; i < DEPTH; i++) begin
            img[i*DATA_W +: DATA_W] = INIT_BASE | DATA_W'(i % 256);
        end
        return img;
    endfunction

    // Contents come up pre-loaded and are deliberately outside the reset domain.
    logic [DEPTH-1:0][DATA_W-1:0] ram = init_image();

    state_e            state_q, state_d;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [BYTES-1:0]  be_q;
    logic [CW-1:0]     wait_cnt;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_status_q;
    logic              end_sim_q;
    logic [15:0]       txn_cnt_q;
    logic [15:0]       err_cnt_q;

    logic [ADDR_W-1:0] off;
    logic              addr_err;
    logic [IW-1:0]     widx;
    logic [DATA_W-1:0] exec_data;
    logic [1:0]        exec_status;
    logic              wr_en;
    logic              req_ready;
    logic              rsp_valid;

    // The offset wraps, so an address below the base is caught by the explicit compare.
    always_comb begin
        off      = addr_q - BASE_ADDR;
        addr_err = (addr_q < BASE_ADDR)
                || ((off % ADDR_W'(BYTES)) != '0)
                || ((off / ADDR_W'(BYTES)) >= ADDR_W'(DEPTH));
        widx     = IW'(off / ADDR_W'(BYTES));
    end

    always_comb begin
        exec_data   = '0;
        exec_status = ST_OK;
        wr_en       = 1'b0;
        case (cmd_q)
            CMD_READ: begin
                if (addr_err) begin
                    exec_status = ST_ADDR;
                end else begin
                    for (int k = 0; k < BYTES; k++) begin
                        exec_data[8*k +: 8] = be_q[k] ? ram[widx][8*k +: 8] : 8'h00;
                    end
                end
            end
            CMD_WRITE: begin
                if (addr_err)          exec_status = ST_ADDR;
                else if (be_q == '0)   exec_status = ST_BE;
                else                   wr_en       = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) state_d = EXEC;
            end
            EXEC: state_d = WAIT;
            WAIT: if (wait_cnt == CW'(RSP_LAT)) state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            be_q         <= '0;
            wait_cnt     <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            end_sim_q    <= 1'b0;
            txn_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        cmd_q  <= bus.req_cmd_i;
                        addr_q <= bus.req_addr_i;
                        data_q <= bus.req_data_i;
                        be_q   <= bus.req_be_i;
                    end
                end
                EXEC: begin
                    rsp_data_q   <= exec_data;
                    rsp_status_q <= exec_status;
                    wait_cnt     <= '0;
                end
                WAIT: wait_cnt <= wait_cnt + 1'b1;
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_data_q   <= '0;
                        rsp_status_q <= ST_OK;
                        if (txn_cnt_q != 16'hFFFF) txn_cnt_q <= txn_cnt_q + 16'd1;
                        if (rsp_status_q != ST_OK && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                        if (cmd_q == CMD_END) end_sim_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A reset that is high at the execute edge must suppress the commit.
    always_ff @(posedge clk_i) begin
        if (state_q == EXEC && wr_en && !rst_i) begin
            for (int k = 0; k < BYTES; k++) begin
                if (be_q[k]) ram[widx][8*k +: 8] <= data_q[8*k +: 8];
            end
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_data_o   = rsp_data_q;
    assign bus.rsp_status_o = rsp_status_q;
    assign end_sim_o        = end_sim_q;
    assign txn_cnt_o        = txn_cnt_q;
    assign err_cnt_o        = err_cnt_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_tlm_mem_target_p.sv
// Bench for tlm_mem_target_p: directed transactions against a word-array model with an expected queue.
module tb_tlm_mem_target_p;
    localparam int          DATA_W  = 32;
    localparam int          ADDR_W  = 32;
    localparam int          DEPTH   = 256;
    localparam int          RSP_LAT = 2;
    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam int          EW      = 2 + 2 + DATA_W;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, IGN = 2'd2, ENDS = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        end_sim;
    logic [15:0] txn_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  dbg_state;

    tlm_mem_target_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    tlm_mem_target_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .RSP_LAT(RSP_LAT), .INIT_BASE(32'hAA00_0000)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .end_sim_o(end_sim), .txn_cnt_o(txn_cnt), .err_cnt_o(err_cnt), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // model state
    logic [31:0]   mem [DEPTH];
    logic [EW-1:0] exp_q [$];
    int            m_txn, m_err;
    bit            m_end;
    bit            busy;
    int            acc_edge;
    int            cyc;
    int            n_pass, n_total;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hAA00_0000 | 32'(i);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    // Returns {cmd, status, data} and applies any write to the model memory.
    function automatic logic [EW-1:0] model_txn(input logic [1:0] cmd, input logic [31:0] addr,
                                                input logic [31:0] data, input logic [3:0] be);
        logic [1:0]  st;
        logic [31:0] rd;
        logic [31:0] off;
        bit          bad;
        int          idx;
        st  = 2'd0;
        rd  = '0;
        off = addr - BASE;
        bad = (addr < BASE) || (off % 32'd4 != 0) || (off / 32'd4 >= 32'(DEPTH));
        idx = bad ? 0 : int'(off / 32'd4);
        if (cmd == RD) begin
            if (bad) st = 2'd1;
            else for (int b = 0; b < 4; b++) if (be[b]) rd[8*b +: 8] = mem[idx][8*b +: 8];
        end else if (cmd == WR) begin
            if (bad) st = 2'd1;
            else if (be == 4'h0) st = 2'd3;
            else for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        return {cmd, st, rd};
    endfunction

    // scoreboard: every negedge
    initial begin
        logic [EW-1:0] e;
        cyc = 0; busy = 0; acc_edge = 0; m_txn = 0; m_err = 0; m_end = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy = 0; m_txn = 0; m_err = 0; m_end = 0;
                exp_q.delete();
                check("rst_req_ready", bus.req_ready_o, 1);
                check("rst_rsp_valid", bus.rsp_valid_o, 0);
                check("rst_rsp_data", bus.rsp_data_o, 0);
                check("rst_rsp_status", bus.rsp_status_o, 0);
                check("rst_txn_cnt", txn_cnt, 0);
                check("rst_err_cnt", err_cnt, 0);
                check("rst_end_sim", end_sim, 0);
            end else begin
                check("req_ready", bus.req_ready_o, !busy);
                check("rsp_valid", bus.rsp_valid_o, busy && (cyc >= acc_edge + 2 + RSP_LAT));
                check("txn_cnt", txn_cnt, m_txn);
                check("err_cnt", err_cnt, m_err);
                check("end_sim", end_sim, m_end);
                if (bus.rsp_valid_o) begin
                    check("rsp_pending", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q[0];
                        check("rsp_data", bus.rsp_data_o, e[DATA_W-1:0]);
                        check("rsp_status", bus.rsp_status_o, e[DATA_W+1:DATA_W]);
                        if (bus.rsp_ready_i) begin
                            void'(exp_q.pop_front());
                            if (m_txn < 65535) m_txn++;
                            if (e[DATA_W+1:DATA_W] != 2'd0 && m_err < 65535) m_err++;
                            if (e[EW-1:EW-2] == ENDS) m_end = 1;
                            busy = 0;
                        end
                    end
                end else if (!busy) begin
                    check("idle_rsp_data", bus.rsp_data_o, 0);
                    check("idle_rsp_status", bus.rsp_status_o, 0);
                end
                if (bus.req_valid_i && bus.req_ready_o) begin
                    busy = 1;
                    acc_edge = cyc + 1;
                end
            end
        end
    end

    // driver
    task automatic do_txn(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] gd, output logic [1:0] gs);
        int n;
        exp_q.push_back(model_txn(cmd, addr, data, be));
        if (hold > 0) bus.rsp_ready_i = 1'b0;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready_wait", n < 50, 1);
        bus.req_valid_i = 1'b1;
        bus.req_cmd_i   = cmd;
        bus.req_addr_i  = addr;
        bus.req_data_i  = data;
        bus.req_be_i    = be;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        n = 0;
        while (!bus.rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
        check("latency", n, RSP_LAT + 2);
        gd = bus.rsp_data_o;
        gs = bus.rsp_status_o;
        if (hold > 0) begin
            // requests offered while busy must be ignored
            bus.req_valid_i = 1'b1;
            bus.req_cmd_i   = WR;
            bus.req_addr_i  = BASE;
            bus.req_data_i  = 32'hDEAD_BEEF;
            bus.req_be_i    = 4'hF;
            repeat (hold) begin @(posedge clk); #1; end
            bus.req_valid_i = 1'b0;
            bus.rsp_ready_i = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] gd;
        logic [1:0]  gs;
        rst = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_cmd_i   = '0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.req_be_i    = '0;
        bus.rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", bus.req_ready_o, 1);
        check("reset_rsp_valid", bus.rsp_valid_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic read of initial contents
        do_txn(RD, 32'h1000, 32'h0, 4'hF, 0, gd, gs);
        check("t1_data", gd, 32'hAA00_0000);
        check("t1_status", gs, 2'd0);
        check("t1_txn_cnt", txn_cnt, 1);

        // byte-enabled write and masked reads
        do_txn(WR, 32'h1004, 32'h1122_3344, 4'b0101, 0, gd, gs);
        check("t2_wr_status", gs, 2'd0);
        do_txn(RD, 32'h1004, 32'h0, 4'hF, 0, gd, gs);
        check("t2_rd_full", gd, 32'hAA22_0044);
        do_txn(RD, 32'h1004, 32'h0, 4'b0011, 0, gd, gs);
        check("t2_rd_low", gd, 32'h0000_0044);

        // address errors leave memory untouched
        do_txn(RD, 32'h1002, 32'h0, 4'hF, 0, gd, gs);
        check("t3_misaligned", gs, 2'd1);
        do_txn(WR, 32'h1400, 32'h5555_5555, 4'hF, 0, gd, gs);
        check("t3_past_end", gs, 2'd1);
        do_txn(RD, 32'h0FFC, 32'h0, 4'hF, 0, gd, gs);
        check("t3_below_base", gs, 2'd1);
        check("t3_err_cnt", err_cnt, 3);
        do_txn(RD, 32'h1000, 32'h0, 4'hF, 0, gd, gs);
        check("t3_word0", gd, 32'hAA00_0000);
        do_txn(RD, 32'h13FC, 32'h0, 4'hF, 0, gd, gs);
        check("t3_word255", gd, 32'hAA00_00FF);

        // byte-enable error and ignore command
        do_txn(WR, 32'h1008, 32'h7777_7777, 4'h0, 0, gd, gs);
        check("t4_be_err", gs, 2'd3);
        do_txn(IGN, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 0, gd, gs);
        check("t4_ign_status", gs, 2'd0);
        check("t4_ign_data", gd, 32'h0);
        do_txn(RD, 32'h1008, 32'h0, 4'hF, 0, gd, gs);
        check("t4_word2", gd, 32'hAA00_0002);
        check("t4_err_cnt", err_cnt, 4);

        // response back-pressure
        do_txn(RD, 32'h1004, 32'h0, 4'hF, 5, gd, gs);
        check("t5_data", gd, 32'hAA22_0044);
        repeat (5) @(posedge clk);
        #1;
        check("t5_txn_cnt", txn_cnt, 13);
        check("t5_err_cnt", err_cnt, 4);

        // reset while the write sits in WAIT
        exp_q.push_back(model_txn(WR, 32'h100C, 32'hCAFE_F00D, 4'hF));
        bus.req_valid_i = 1'b1;
        bus.req_cmd_i   = WR;
        bus.req_addr_i  = 32'h100C;
        bus.req_data_i  = 32'hCAFE_F00D;
        bus.req_be_i    = 4'hF;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_req_ready", bus.req_ready_o, 1);
        check("t6_rsp_valid", bus.rsp_valid_o, 0);
        check("t6_rsp_data", bus.rsp_data_o, 0);
        check("t6_txn_cnt", txn_cnt, 0);
        check("t6_err_cnt", err_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_txn(RD, 32'h100C, 32'h0, 4'hF, 0, gd, gs);
        check("t6_committed", gd, 32'hCAFE_F00D);
        check("t6_txn_after", txn_cnt, 1);
        do_txn(ENDS, 32'h0, 32'h0, 4'h0, 0, gd, gs);
        check("t6_end_status", gs, 2'd0);
        check("t6_end_sim", end_sim, 1);
        do_txn(RD, 32'h1000, 32'h0, 4'hF, 0, gd, gs);
        check("t6_after_end", gd, 32'hAA00_0000);
        check("t6_end_sticky", end_sim, 1);
        rst = 1'b1;
        #1;
        check("t6_end_cleared", end_sim, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
